// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: byte stream in, preamble/SFD/payload/[pad]/FCS/IFG out, one byte per clock.
// Optional minimum-size zero padding is built when GMII_TX_PAD_EN is defined.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy
);

  // The state names the byte currently on the wire; the last payload byte is
  // shown while already in PAD/FCS, and the underrun error byte while in ABORT.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] SFD   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] PAD   = 3'd4;
  localparam logic [2:0] FCS   = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;
  localparam logic [2:0] IFG   = 3'd7;

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [10:0] byte_cnt;
  logic [31:0] crc;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign s_ready = (state == SFD) || (state == DATA);
  assign busy    = (state != IDLE);

  logic        accept;
  logic [10:0] cnt_inc;
  logic        short_frame;
  logic [31:0] crc_data;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  assign accept      = s_ready & s_valid;
  assign cnt_inc     = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign short_frame = ({1'b0, cnt_inc} < MIN_LEN);
  assign crc_data    = crc_next(crc, s_data);
  assign fcs         = ~crc;
  assign fcs_byte    = 8'(fcs >> {cnt[1:0], 3'b000});

`ifdef GMII_TX_PAD_EN
  logic [31:0] crc_pad;
  assign crc_pad = crc_next(crc, 8'h00);
`endif

  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      byte_cnt   <= 11'd0;
      crc        <= 32'hFFFF_FFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
    end else begin
      // NOTE: idle defaults first, overridden below; with non-blocking
      // assignments the last write in the block wins, so no branch can leave a
      // stale byte on the wire.
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= 11'd0;
          crc      <= 32'hFFFF_FFFF;
          cnt      <= 8'd1;
          if (s_valid) begin
            state      <= PRE;
            gmii_txd   <= 8'h55;
            gmii_tx_en <= 1'b1;
          end
        end
        PRE: begin
          gmii_tx_en <= 1'b1;
          if (cnt < PRE_LAST) begin
            gmii_txd <= 8'h55;
            cnt      <= cnt + 8'd1;
          end else begin
            gmii_txd <= 8'hD5;
            state    <= SFD;
          end
        end
        SFD, DATA: begin
          gmii_tx_en <= 1'b1;
          if (accept) begin
            gmii_txd   <= s_data;
            gmii_tx_er <= s_err;
            crc        <= crc_data;
            byte_cnt   <= cnt_inc;
            if (s_last) begin
              cnt   <= 8'd0;
              state <= (PAD_EN && short_frame) ? PAD : FCS;
            end else begin
              state <= DATA;
            end
          end else begin
            gmii_tx_er <= 1'b1;
            state      <= ABORT;
          end
        end
`ifdef GMII_TX_PAD_EN
        PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc_pad;
          byte_cnt   <= cnt_inc;
          cnt        <= 8'd0;
          if ({1'b0, cnt_inc} >= MIN_LEN) state <= FCS;
        end
`endif
        FCS: begin
          if (cnt < 8'd4) begin
            gmii_txd   <= fcs_byte;
            gmii_tx_en <= 1'b1;
            cnt        <= cnt + 8'd1;
          end else begin
            cnt   <= 8'd1;
            state <= IFG;
          end
        end
        ABORT: begin
          cnt   <= 8'd1;
          state <= IFG;
        end
        IFG: begin
          if (cnt < IFG_LAST) cnt <= cnt + 8'd1;
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random frames checked cycle-by-cycle against a frame-level model.
// Follows GMII_TX_PAD_EN the same way the design does.
module tb_gmii_tx_framer;

  localparam int PRE_N = 7;
  localparam int MIN_N = 60;
  localparam int IFG_N = 12;

  logic       gmii_tx_clk = 1'b0;
  logic       reset_n     = 1'b0;
  logic [7:0] s_data      = 8'h00;
  logic       s_valid     = 1'b0;
  logic       s_last      = 1'b0;
  logic       s_err       = 1'b0;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       busy;

  gmii_tx_framer #(.PREAMBLE_LEN(PRE_N), .MIN_FRAME(MIN_N), .IFG_BYTES(IFG_N)) dut (
    .gmii_tx_clk(gmii_tx_clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_err(s_err), .s_ready(s_ready),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .busy(busy)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] txd;
    logic       bsy;
    logic       rdy;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  obs_t expq[$];
  obs_t capq[$];

  // Frames queued for the next run: flattened bytes plus per-frame length and cut point (-1 = complete).
  logic [7:0] fr_data[$];
  logic       fr_err[$];
  int         fr_len[$];
  int         fr_cut[$];

  function automatic obs_t mk(logic en, logic er, logic [7:0] txd, logic bsy, logic rdy);
    obs_t o;
    o.en = en; o.er = er; o.txd = txd; o.bsy = bsy; o.rdy = rdy;
    return o;
  endfunction

  // Bit-serial IEEE 802.3 CRC register (not inverted).
  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic void clear_frames();
    fr_data.delete(); fr_err.delete(); fr_len.delete(); fr_cut.delete();
  endfunction

  function automatic void add_frame(int n, int cut, int err_idx, bit rand_err);
    for (int i = 0; i < n; i++) begin
      fr_data.push_back(8'($urandom));
      fr_err.push_back((i == err_idx) || (rand_err && ($urandom_range(0, 15) == 0)));
    end
    fr_len.push_back(n);
    fr_cut.push_back(cut);
  endfunction

  // Expected wire activity, one entry per clock, from the first IDLE cycle to the end of IFG.
  function automatic void model_frame(int off, int n, int cut);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    expq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    repeat (PRE_N) expq.push_back(mk(1'b1, 1'b0, 8'h55, 1'b1, 1'b0));
    expq.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b1, 1'b1));
    if (cut >= 0) begin
      for (int i = 0; i < cut; i++)
        expq.push_back(mk(1'b1, fr_err[off+i], fr_data[off+i], 1'b1, 1'b1));
      expq.push_back(mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0));
    end else begin
      for (int i = 0; i < n; i++) begin
        expq.push_back(mk(1'b1, fr_err[off+i], fr_data[off+i], 1'b1, i < n - 1));
        body.push_back(fr_data[off+i]);
      end
`ifdef GMII_TX_PAD_EN
      while (body.size() < MIN_N) begin
        expq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
        body.push_back(8'h00);
      end
`endif
      fcs = ~crc32(body);
      for (int k = 0; k < 4; k++) expq.push_back(mk(1'b1, 1'b0, fcs[8*k +: 8], 1'b1, 1'b0));
    end
    repeat (IFG_N) expq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
  endfunction

  task automatic drive_frames(input string name);
    int  off;
    off = 0;
    foreach (fr_len[f]) begin
      int  n, cut, nsend, idx, budget;
      logic rdy;
      n = fr_len[f]; cut = fr_cut[f];
      nsend = (cut >= 0) ? cut : n;
      idx = 0; budget = 0;
      s_valid = 1'b1; s_data = fr_data[off]; s_err = fr_err[off];
      s_last = (cut < 0) && (n == 1);
      while (idx < nsend) begin
        @(negedge gmii_tx_clk); rdy = s_ready;
        @(posedge gmii_tx_clk); #1;
        if (rdy) begin
          idx++;
          if (idx < nsend) begin
            s_data = fr_data[off+idx]; s_err = fr_err[off+idx];
            s_last = (cut < 0) && (idx == n - 1);
          end
        end
        budget++;
        if (budget > 4000) begin
          checks++; errors++;
          $display("FAIL %s handshake timeout: frame %0d accepted %0d of %0d bytes", name, f, idx, nsend);
          break;
        end
      end
      if (cut >= 0) begin
        s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
        @(posedge gmii_tx_clk); #1;
      end
      off += n;
    end
    s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    int off;
    expq.delete(); capq.delete();
    off = 0;
    foreach (fr_len[f]) begin
      model_frame(off, fr_len[f], fr_cut[f]);
      off += fr_len[f];
    end
    expq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    @(posedge gmii_tx_clk); #1;
    fork
      drive_frames(name);
      repeat (expq.size()) begin
        @(negedge gmii_tx_clk);
        capq.push_back(mk(gmii_tx_en, gmii_tx_er, gmii_txd, busy, s_ready));
      end
    join
    foreach (expq[i]) begin
      checks++;
      if (capq[i] !== expq[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got en=%b er=%b txd=%h busy=%b ready=%b, want en=%b er=%b txd=%h busy=%b ready=%b",
                 name, i, capq[i].en, capq[i].er, capq[i].txd, capq[i].bsy, capq[i].rdy,
                 expq[i].en, expq[i].er, expq[i].txd, expq[i].bsy, expq[i].rdy);
      end
    end
  endtask

  function automatic int count_en();
    int c;
    c = 0;
    foreach (capq[i]) if (capq[i].en === 1'b1) c++;
    return c;
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({gmii_tx_en, gmii_tx_er, gmii_txd, s_ready, busy} !== 12'h000) begin
      errors++;
      $display("FAIL %s: got en=%b er=%b txd=%h ready=%b busy=%b, want all zero",
               name, gmii_tx_en, gmii_tx_er, gmii_txd, s_ready, busy);
    end
  endtask

  task automatic test_reset();
    #13;
    check_idle_outputs("reset_asserted");
    @(negedge gmii_tx_clk); reset_n = 1'b1;
    repeat (3) begin
      @(negedge gmii_tx_clk);
      check_idle_outputs("reset_released_idle");
    end
  endtask

  task automatic test_known_vector();
    int n_en;
    clear_frames();
    add_frame(9, -1, -1, 1'b0);
    for (int i = 0; i < 9; i++) fr_data[i] = 8'h31 + 8'(i);
    run_and_check("known_vector");
    n_en = count_en();
`ifdef GMII_TX_PAD_EN
    checks++;
    if (n_en != PRE_N + 1 + MIN_N + 4) begin
      errors++;
      $display("FAIL known_vector_en_len: got %0d cycles, want %0d", n_en, PRE_N + 1 + MIN_N + 4);
    end
`else
    begin
      logic [31:0] want;
      want = 32'hCBF4_3926;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (capq[1+PRE_N+1+9+k].txd !== want[8*k +: 8]) begin
          errors++;
          $display("FAIL known_vector_fcs%0d: got %h, want %h", k, capq[1+PRE_N+1+9+k].txd, want[8*k +: 8]);
        end
      end
      checks++;
      if (n_en != PRE_N + 1 + 9 + 4) begin
        errors++;
        $display("FAIL known_vector_en_len: got %0d cycles, want %0d", n_en, PRE_N + 1 + 9 + 4);
      end
    end
`endif
  endtask

  task automatic test_long_frame();
    int n_en;
    clear_frames();
    add_frame(100, -1, -1, 1'b0);
    run_and_check("long_frame");
    n_en = count_en();
    checks++;
    if (n_en != 112) begin
      errors++;
      $display("FAIL long_frame_en_len: got %0d cycles, want 112", n_en);
    end
  endtask

  task automatic test_err_byte();
    clear_frames();
    add_frame(30, -1, 4, 1'b0);
    run_and_check("err_byte5");
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 6; t++) begin
      clear_frames();
      add_frame($urandom_range(1, 80), -1, -1, 1'b1);
      run_and_check($sformatf("random_frame%0d", t));
    end
  endtask

  task automatic test_underrun();
    clear_frames();
    add_frame(20, 20, -1, 1'b0);
    add_frame($urandom_range(5, 40), -1, -1, 1'b0);
    run_and_check("underrun_then_next");
    clear_frames();
    add_frame(1, 1, -1, 1'b0);
    run_and_check("underrun_after_one");
  endtask

  task automatic test_back_to_back();
    clear_frames();
    add_frame(1, -1, -1, 1'b0);
    add_frame($urandom_range(2, 70), -1, -1, 1'b1);
    add_frame($urandom_range(55, 75), -1, -1, 1'b1);
    run_and_check("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    @(posedge gmii_tx_clk); #1;
    s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
    repeat (PRE_N + 1 + 5) begin
      @(posedge gmii_tx_clk); #1;
      s_data = 8'($urandom);
    end
    #1;
    checks++;
    if (busy !== 1'b1 || gmii_tx_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_active: got busy=%b en=%b, want 1 1", busy, gmii_tx_en);
    end
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_frame");
    s_valid = 1'b0;
    @(negedge gmii_tx_clk); reset_n = 1'b1;
    clear_frames();
    add_frame($urandom_range(10, 70), -1, -1, 1'b0);
    run_and_check("after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_long_frame();
    test_err_byte();
    test_random_frames();
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
